rst_sequencer: RTL and testbench

- Parametrised power-on/manual reset sequencer for FPGA top-level wrappers.
- Sits between the PLL output clock and the user design.
- Holds all reset domains asserted until the manual button is released and debounced and the PLL lock is stable.
- Releases N reset domains in staggered order, and re-enters reset on manual press or lock loss, recording the cause.

---
 rtl/rst_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_rst_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Staggered power-on / manual reset sequencer with debounced button, lock qualification and cause capture.
// Optional watchdog re-entry into reset is compiled in with `define RST_SEQ_WDT_EN.
module rst_sequencer #(
  parameter int N_DOMAINS       = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int LOCK_CYCLES     = 16,
  parameter int STAGE_GAP       = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 manual_rst,
  input  logic                 pll_lock,
  input  logic                 wdt_kick,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 sys_ready,
  output logic [1:0]           state_o,
  output logic [1:0]           rst_cause
);

  localparam int HCW        = $clog2(HOLD_CYCLES + 1);
  localparam int LCW        = $clog2(LOCK_CYCLES + 1);
  localparam int DCW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STAGE_LAST = (N_DOMAINS - 1) * STAGE_GAP;
  localparam int SCW        = $clog2(STAGE_LAST + 2);

  localparam logic [HCW-1:0] HOLD_MAX   = HCW'(HOLD_CYCLES);
  localparam logic [LCW-1:0] LOCK_MAX   = LCW'(LOCK_CYCLES);
  localparam logic [DCW-1:0] DB_MAX     = DCW'(DEBOUNCE_CYCLES);
  localparam logic [SCW-1:0] STAGE_END  = SCW'(STAGE_LAST);
  localparam logic [N_DOMAINS-1:0] FIRST_MASK = {N_DOMAINS{1'b1}} << 1;

  localparam logic [1:0] CAUSE_POWER  = 2'd0;
  localparam logic [1:0] CAUSE_MANUAL = 2'd1;
  localparam logic [1:0] CAUSE_LOCK   = 2'd2;
  localparam logic [1:0] CAUSE_WDT    = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [N_DOMAINS-1:0] rst_out_reg, rst_out_next, rel_mask;
  logic                 ready_reg, ready_next;
  logic [1:0]           cause_reg, cause_next, fault_code;
  logic                 fault;
  logic                 man_meta_reg, man_s_reg, lock_meta_reg, lock_s_reg;
  logic [DCW-1:0]       db_cnt_reg, db_cnt_next;
  logic [HCW-1:0]       hold_cnt_reg, hold_next, hold_inc;
  logic [LCW-1:0]       lock_cnt_reg, lock_next, lock_inc;
  logic [SCW-1:0]       stage_reg, stage_next, stage_inc;
  logic                 man_db;
  logic                 wdt_fire;

  // man_db is the value the debounce flag takes on this edge, so the
  // button acts exactly DEBOUNCE_CYCLES after the synchronised rise.
  always_comb begin
    db_cnt_next = db_cnt_reg;
    if (!man_s_reg)
      db_cnt_next = '0;
    else if (db_cnt_reg != DB_MAX)
      db_cnt_next = db_cnt_reg + DCW'(1);
    man_db = (db_cnt_next == DB_MAX);
  end

  assign hold_inc  = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + HCW'(1);
  assign lock_inc  = (lock_cnt_reg == LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + LCW'(1);
  assign stage_inc = (stage_reg == STAGE_END)   ? stage_reg    : stage_reg + SCW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N_DOMAINS; gi++) begin : g_mask
      assign rel_mask[gi] = (int'(stage_inc) < gi * STAGE_GAP);
    end
  endgenerate

`ifdef RST_SEQ_WDT_EN
  localparam int WCW = $clog2(WDT_CYCLES + 1);
  localparam logic [WCW-1:0] WDT_MAX = WCW'(WDT_CYCLES);

  logic           kick_meta_reg, kick_s_reg;
  logic [WCW-1:0] wdt_cnt_reg, wdt_inc;

  assign wdt_inc  = (wdt_cnt_reg == WDT_MAX) ? wdt_cnt_reg : wdt_cnt_reg + WCW'(1);
  assign wdt_fire = (state_reg == S_RUN) && !kick_s_reg && (wdt_inc == WDT_MAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      kick_meta_reg <= 1'b0;
      kick_s_reg    <= 1'b0;
      wdt_cnt_reg   <= '0;
    end else begin
      kick_meta_reg <= wdt_kick;
      kick_s_reg    <= kick_meta_reg;
      wdt_cnt_reg   <= (state_reg == S_RUN && state_next == S_RUN && !kick_s_reg) ? wdt_inc : '0;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES != 0);
  assign wdt_fire   = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    rst_out_next = rst_out_reg;
    ready_next   = 1'b0;
    cause_next   = cause_reg;
    hold_next    = hold_cnt_reg;
    lock_next    = '0;
    stage_next   = '0;
    fault        = 1'b0;
    fault_code   = CAUSE_MANUAL;
    unique case (state_reg)
      S_HOLD: begin
        rst_out_next = '1;
        if (man_db) begin
          hold_next = '0;
        end else begin
          hold_next = hold_inc;
          if (hold_inc == HOLD_MAX)
            state_next = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        rst_out_next = '1;
        hold_next    = '0;
        fault        = man_db;
        if (lock_s_reg) begin
          lock_next = lock_inc;
          if (lock_inc == LOCK_MAX) begin
            state_next   = S_RELEASE;
            rst_out_next = FIRST_MASK;
          end
        end
      end
      S_RELEASE: begin
        fault      = man_db || !lock_s_reg;
        fault_code = man_db ? CAUSE_MANUAL : CAUSE_LOCK;
        if (stage_reg == STAGE_END) begin
          state_next   = S_RUN;
          rst_out_next = '0;
          ready_next   = 1'b1;
        end else begin
          stage_next   = stage_inc;
          rst_out_next = rel_mask;
        end
      end
      S_RUN: begin
        rst_out_next = '0;
        ready_next   = 1'b1;
        fault        = man_db || !lock_s_reg || wdt_fire;
        fault_code   = man_db ? CAUSE_MANUAL : (!lock_s_reg ? CAUSE_LOCK : CAUSE_WDT);
      end
      default: ;
    endcase
    // A fault wins over any forward transition and re-asserts every domain on this edge.
    if (fault) begin
      state_next   = S_HOLD;
      rst_out_next = '1;
      ready_next   = 1'b0;
      cause_next   = fault_code;
      hold_next    = '0;
      lock_next    = '0;
      stage_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= S_HOLD;
      rst_out_reg   <= '1;
      ready_reg     <= 1'b0;
      cause_reg     <= CAUSE_POWER;
      man_meta_reg  <= 1'b0;
      man_s_reg     <= 1'b0;
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
      db_cnt_reg    <= '0;
      hold_cnt_reg  <= '0;
      lock_cnt_reg  <= '0;
      stage_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      rst_out_reg   <= rst_out_next;
      ready_reg     <= ready_next;
      cause_reg     <= cause_next;
      man_meta_reg  <= manual_rst;
      man_s_reg     <= man_meta_reg;
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
      db_cnt_reg    <= db_cnt_next;
      hold_cnt_reg  <= hold_next;
      lock_cnt_reg  <= lock_next;
      stage_reg     <= stage_next;
    end
  end

  assign rst_out   = rst_out_reg;
  assign sys_ready = ready_reg;
  assign state_o   = state_reg;
  assign rst_cause = cause_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: power-on table, directed corner sequences and random stimulus
// against an elapsed-time reference model. Watchdog checks follow RST_SEQ_WDT_EN.
module tb_rst_sequencer;

  localparam int N = 3, H = 4, L = 16, G = 2, D = 8, W = 64;
  localparam int MAXE = 8192;

  logic         clk = 1'b0;
  logic         nrst = 1'b1;
  logic         manual_rst = 1'b0;
  logic         pll_lock = 1'b1;
  logic         wdt_kick = 1'b0;
  logic [N-1:0] rst_out;
  logic         sys_ready;
  logic [1:0]   state_o;
  logic [1:0]   rst_cause;

  rst_sequencer #(
    .N_DOMAINS(N), .HOLD_CYCLES(H), .LOCK_CYCLES(L),
    .STAGE_GAP(G), .DEBOUNCE_CYCLES(D), .WDT_CYCLES(W)
  ) dut (
    .clk(clk), .nrst(nrst), .manual_rst(manual_rst), .pll_lock(pll_lock),
    .wdt_kick(wdt_kick), .rst_out(rst_out), .sys_ready(sys_ready),
    .state_o(state_o), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: raw input history per edge since reset, plus the edge at
  // which each relevant interval started.
  bit man_in [0:MAXE-1];
  bit lock_in[0:MAXE-1];
  bit kick_in[0:MAXE-1];
  int n, m_ph, m_cause, hold_ref, lock_ref, rel_start, wdt_ref;

  function automatic bit man_at(int i);  return (i >= 1) ? man_in[i]  : 1'b0; endfunction
  function automatic bit lock_at(int i); return (i >= 1) ? lock_in[i] : 1'b0; endfunction
  function automatic bit kick_at(int i); return (i >= 1) ? kick_in[i] : 1'b0; endfunction

  task automatic model_reset();
    n = 0; m_ph = 0; m_cause = 0; hold_ref = 0; lock_ref = 0; rel_start = 0; wdt_ref = 0;
  endtask

  task automatic model_edge();
    bit mdb, lk, kk, flt;
    int fc;
    if (n < MAXE - 1) n++;
    man_in[n] = manual_rst; lock_in[n] = pll_lock; kick_in[n] = wdt_kick;
    // inputs are seen by the sequencer two edges after they are sampled
    mdb = 1'b1;
    for (int j = 0; j < D; j++) if (!man_at(n - 2 - j)) mdb = 1'b0;
    lk = lock_at(n - 2);
    kk = kick_at(n - 2);
    flt = 1'b0; fc = 0;
    if (m_ph != 0 && mdb) begin flt = 1'b1; fc = 1; end
    else if (m_ph >= 2 && !lk) begin flt = 1'b1; fc = 2; end
`ifdef RST_SEQ_WDT_EN
    else if (m_ph == 3 && !kk && (n - wdt_ref) >= W) begin flt = 1'b1; fc = 3; end
`endif
    if (flt) begin
      m_ph = 0; m_cause = fc; hold_ref = n;
    end else begin
      case (m_ph)
        0: if (mdb) hold_ref = n;
           else if (n - hold_ref >= H) begin m_ph = 1; lock_ref = n; end
        1: if (!lk) lock_ref = n;
           else if (n - lock_ref >= L) begin m_ph = 2; rel_start = n; end
        2: if (n - rel_start > (N - 1) * G) begin m_ph = 3; wdt_ref = n; end
        default: if (kk) wdt_ref = n;
      endcase
    end
  endtask

  function automatic logic [7:0] model_pack();
    logic [N-1:0] r;
    r = '0;
    if (m_ph <= 1) r = '1;
    else if (m_ph == 2) for (int k = 0; k < N; k++) r[k] = ((n - rel_start) < k * G);
    return {2'(m_ph), r, (m_ph == 3), 2'(m_cause)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input logic [2:0] ro,
                            input logic rdy, input logic [1:0] ca);
    check(name, {24'd0, state_o, rst_out, sys_ready, rst_cause}, {24'd0, st, ro, rdy, ca});
  endtask

  task automatic step();
    @(posedge clk);
    if (nrst) model_edge();
    #1;
    cyc++;
    check("model", {24'd0, state_o, rst_out, sys_ready, rst_cause}, {24'd0, model_pack()});
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    #1 expect_out("async_reset", 2'd0, 3'b111, 1'b0, 2'd0);
    model_reset();
    steps(2);
    nrst = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (state_o !== s && k < budget) begin step(); k++; end
    check(name, {30'd0, state_o}, {30'd0, s});
  endtask

  typedef struct {
    int         cyc;
    logic       lock;
    logic [1:0] st;
    logic [2:0] ro;
    logic       rdy;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3,  1'b1, 2'd0, 3'b111, 1'b0, 2'd0};
    tbl[1] = '{4,  1'b1, 2'd1, 3'b111, 1'b0, 2'd0};
    tbl[2] = '{19, 1'b1, 2'd1, 3'b111, 1'b0, 2'd0};
    tbl[3] = '{20, 1'b1, 2'd2, 3'b110, 1'b0, 2'd0};
    tbl[4] = '{21, 1'b1, 2'd2, 3'b110, 1'b0, 2'd0};
    tbl[5] = '{22, 1'b1, 2'd2, 3'b100, 1'b0, 2'd0};
    tbl[6] = '{24, 1'b1, 2'd2, 3'b000, 1'b0, 2'd0};
    tbl[7] = '{25, 1'b1, 2'd3, 3'b000, 1'b1, 2'd0};

    // Power-on timing
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      foreach (tbl[i]) if (tbl[i].cyc == c) pll_lock = tbl[i].lock;
      step();
      foreach (tbl[i])
        if (tbl[i].cyc == c)
          expect_out($sformatf("poweron_c%0d", c), tbl[i].st, tbl[i].ro, tbl[i].rdy, tbl[i].cause);
    end

    // Late lock with a glitch: counter restarts on the last lock_s rise (after edge 55)
    pll_lock = 1'b0;
    do_reset();
    steps(40);
    expect_out("late_wait40", 2'd1, 3'b111, 1'b0, 2'd0);
    pll_lock = 1'b1; steps(10);
    pll_lock = 1'b0; steps(3);
    pll_lock = 1'b1; steps(17);
    expect_out("late_wait70", 2'd1, 3'b111, 1'b0, 2'd0);
    step();
    expect_out("late_rel71", 2'd2, 3'b110, 1'b0, 2'd0);
    wait_state(2'd3, 20, "late_run");

    // Manual button: short press ignored, long press acts after 2+8 cycles
    manual_rst = 1'b1; steps(5);
    manual_rst = 1'b0; steps(15);
    expect_out("short_press", 2'd3, 3'b000, 1'b1, 2'd0);
    manual_rst = 1'b1; steps(9);
    expect_out("press_9", 2'd3, 3'b000, 1'b1, 2'd0);
    step();
    expect_out("press_10", 2'd0, 3'b111, 1'b0, 2'd1);
    steps(2);
    expect_out("press_held", 2'd0, 3'b111, 1'b0, 2'd1);
    manual_rst = 1'b0;
    wait_state(2'd3, 60, "manual_restart");
    expect_out("manual_cause_kept", 2'd3, 3'b000, 1'b1, 2'd1);

    // Lock loss after rst_out[0] released
    do_reset();
    steps(20);
    expect_out("ll_release", 2'd2, 3'b110, 1'b0, 2'd0);
    pll_lock = 1'b0; steps(2);
    expect_out("ll_2", 2'd2, 3'b100, 1'b0, 2'd0);
    step();
    expect_out("ll_3", 2'd0, 3'b111, 1'b0, 2'd2);
    pll_lock = 1'b1;
    wait_state(2'd3, 60, "ll_restart");

    // Debounced manual and lock loss on the same edge
    manual_rst = 1'b1; steps(7);
    pll_lock = 1'b0; steps(2);
    expect_out("simul_9", 2'd3, 3'b000, 1'b1, 2'd2);
    step();
    expect_out("simul_10", 2'd0, 3'b111, 1'b0, 2'd1);
    manual_rst = 1'b0; pll_lock = 1'b1;
    wait_state(2'd3, 80, "simul_restart");

    // Watchdog (nrst from RUN also clears the recorded cause)
    do_reset();
    wait_state(2'd3, 40, "wdt_run");
`ifdef RST_SEQ_WDT_EN
    for (int i = 0; i < 6; i++) begin
      wdt_kick = 1'b1; step(); wdt_kick = 1'b0; steps(49);
    end
    expect_out("wdt_kicked", 2'd3, 3'b000, 1'b1, 2'd0);
    wdt_kick = 1'b1; step(); wdt_kick = 1'b0; steps(65);
    expect_out("wdt_last_run", 2'd3, 3'b000, 1'b1, 2'd0);
    step();
    expect_out("wdt_expire", 2'd0, 3'b111, 1'b0, 2'd3);
`else
    steps(300);
    expect_out("no_wdt_run", 2'd3, 3'b000, 1'b1, 2'd0);
`endif

    // Random stimulus against the model
    do_reset();
    for (int s = 0; s < 150; s++) begin
      int len;
      manual_rst = ($urandom_range(0, 3) == 0);
      pll_lock   = ($urandom_range(0, 4) != 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        wdt_kick = ($urandom_range(0, 15) == 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
